// File: rtl/ram_load_ctrl_if.sv
// Bundle of loader, CPU sequencing and RAM port signals around ram_load_ctrl.
// Latency: none, wiring only.
// Backpressure: load_valid/load_ready on the loader stream; the other signals have no handshake.
interface ram_load_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              run_req;
  logic              step_req;
  logic [3:0]        cpu_adr;
  logic              cpu_tick;
  logic              cpu_rst_n;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [1:0]        state;
  logic [ADDR_W:0]   load_count;

  // Controller side
  modport slave (
    input  load_start, load_valid, load_data, load_last, run_req, step_req, cpu_adr,
    output load_ready, cpu_tick, cpu_rst_n, ram_we, ram_addr, ram_w_data, state, load_count
  );

  // Loader, CPU and RAM side
  modport master (
    output load_start, load_valid, load_data, load_last, run_req, step_req, cpu_adr,
    input  load_ready, cpu_tick, cpu_rst_n, ram_we, ram_addr, ram_w_data, state, load_count
  );
endinterface

// File: rtl/ram_load_ctrl.sv
// Arbitrates the program RAM between the byte loader and CPU fetch, and paces the CPU clock enable.
// Latency: RAM signals are combinational in the same cycle; state changes take effect one clk after a request.
// Backpressure: load_ready is high for the whole LOAD state; every valid byte in LOAD is written that cycle.
module ram_load_ctrl #(
  parameter int DIV_W  = 24,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst,
  ram_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0]  DIV_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  state_t            cur;
  logic [DIV_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt_q;
  logic              rdy_q;
  logic              cpu_rst_q;

  logic accept;
  logic term;

  assign accept = (cur == LOAD) && rdy_q && bus.load_valid;
  assign term   = (div_cnt == '1);

  // A RUN tick is dropped in the cycle RUN is being left, so no tick leaks out on exit.
  assign bus.cpu_tick   = (cur == STEP) ||
                          ((cur == RUN) && bus.run_req && !bus.load_start && term);
  assign bus.ram_we     = accept;
  assign bus.ram_addr   = (cur == LOAD) ? ptr : {{(ADDR_W-4){1'b0}}, bus.cpu_adr};
  assign bus.ram_w_data = (cur == LOAD) ? bus.load_data : '0;
  assign bus.state      = cur;
  assign bus.load_ready = rdy_q;
  assign bus.cpu_rst_n  = cpu_rst_q;
  assign bus.load_count = cnt_q;

  // Sequencer: state, tick divider, load pointer and the registered outputs that follow the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= HALT;
      div_cnt   <= '0;
      ptr       <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      case (cur)
        HALT: begin
          div_cnt   <= '0;
          cpu_rst_q <= 1'b1;
          if (bus.load_start) begin
            cur       <= LOAD;
            ptr       <= '0;
            rdy_q     <= 1'b1;
            cpu_rst_q <= 1'b0;
          end else if (bus.step_req) begin
            cur <= STEP;
          end else if (bus.run_req) begin
            cur <= RUN;
          end
        end
        RUN: begin
          if (bus.load_start) begin
            cur       <= LOAD;
            div_cnt   <= '0;
            ptr       <= '0;
            rdy_q     <= 1'b1;
            cpu_rst_q <= 1'b0;
          end else if (!bus.run_req) begin
            cur     <= HALT;
            div_cnt <= '0;
          end else begin
            // Wraps naturally from all-ones back to zero after the tick.
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        STEP: begin
          cur <= HALT;
        end
        LOAD: begin
          if (accept) begin
            ptr <= ptr + PTR_ONE;
            // The full-RAM exit stops the pointer from wrapping onto address 0.
            if (bus.load_last || (ptr == '1)) begin
              cur       <= HALT;
              cnt_q     <= {1'b0, ptr} + CNT_ONE;
              rdy_q     <= 1'b0;
              cpu_rst_q <= 1'b1;
            end
          end
        end
        default: cur <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed bench for ram_load_ctrl with a scoreboard of expected RAM writes and CPU ticks.
// Latency: expected tick cycles are computed from the cycle the request is driven.
// Backpressure: the loader streams only while the controller is in LOAD.
module tb_ram_load_ctrl;
  localparam int DIV_W  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_STEP = 2'd3;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  wr_t exp_wr[$];
  int  exp_tick[$];

  always #5 clk = ~clk;

  ram_load_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_load_ctrl #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every write and every tick the DUT shows must match the head of its queue.
  always @(negedge clk) begin
    if (bus.ram_we) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, want no write (cycle %0d)",
                 bus.ram_addr, bus.ram_w_data, cyc);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", {24'd0, bus.ram_addr}, {24'd0, w.a});
        check("wr_data", {24'd0, bus.ram_w_data}, {24'd0, w.d});
        check("wr_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
      end
    end
    if (bus.cpu_tick) begin
      if (exp_tick.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: cpu_tick=1 at cycle %0d, want 0", cyc);
      end else begin
        int t;
        t = exp_tick.pop_front();
        check("tick_cycle", cyc, t);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals [3];
    int n, i, n0, m0, p0, s;
    logic v;
    logic [7:0] d;

    vals[0] = 8'h11;
    vals[1] = 8'h22;
    vals[2] = 8'h33;

    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.run_req    = 1'b0;
    bus.step_req   = 1'b0;
    bus.cpu_adr    = 4'hA;

    // Reset values
    sample();
    check("rst_state", {30'd0, bus.state}, {30'd0, S_HALT});
    check("rst_tick", {31'd0, bus.cpu_tick}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
    check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    check("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    check("rst_load_count", {23'd0, bus.load_count}, 32'd0);
    next();
    rst = 1'b1;
    next();

    // Idle in HALT
    for (int k = 0; k < 100; k++) begin
      sample();
      check("idle_state", {30'd0, bus.state}, {30'd0, S_HALT});
      check("idle_ram_addr", {24'd0, bus.ram_addr}, 32'h0A);
      check("idle_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd1);
      next();
    end

    // Three-byte load terminated by load_last
    bus.load_start = 1'b1;
    sample();
    next();
    bus.load_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = vals[k];
      bus.load_last  = (k == 2);
      exp_wr.push_back('{a: 8'(k), d: vals[k]});
      sample();
      check("ld3_state", {30'd0, bus.state}, {30'd0, S_LOAD});
      check("ld3_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
      check("ld3_load_ready", {31'd0, bus.load_ready}, 32'd1);
      next();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    sample();
    check("ld3_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    check("ld3_count", {23'd0, bus.load_count}, 32'd3);
    check("ld3_exit_ready", {31'd0, bus.load_ready}, 32'd0);
    check("ld3_exit_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd1);
    next();

    // Full 256-byte load with valid gaps, no load_last
    bus.load_start = 1'b1;
    sample();
    next();
    bus.load_start = 1'b0;
    n = 0;
    i = 0;
    while (n < 256 && i < 2000) begin
      v = ((i % 4) == 0) || ((i % 4) == 3);
      d = 8'(n) ^ 8'hA5;
      bus.load_valid = v;
      bus.load_data  = d;
      if (v) exp_wr.push_back('{a: 8'(n), d: d});
      sample();
      next();
      if (v) n++;
      i++;
    end
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hEE;
    sample();
    check("ld256_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    check("ld256_count", {23'd0, bus.load_count}, 32'd256);
    next();
    bus.load_valid = 1'b0;

    // RUN for 40 cycles with a step_req mid-run
    n0 = cyc;
    bus.run_req = 1'b1;
    exp_tick.push_back(n0 + 16);
    exp_tick.push_back(n0 + 32);
    for (int j = 1; j <= 40; j++) begin
      next();
      bus.step_req = (j == 20);
    end
    bus.step_req = 1'b0;
    bus.run_req  = 1'b0;
    sample();
    check("run1_state_before_exit", {30'd0, bus.state}, {30'd0, S_RUN});
    next();
    sample();
    check("run1_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    next();

    // RUN dropped exactly at terminal count
    m0 = cyc;
    bus.run_req = 1'b1;
    exp_tick.push_back(m0 + 16);
    repeat (32) next();
    bus.run_req = 1'b0;
    sample();
    check("run2_term_tick", {31'd0, bus.cpu_tick}, 32'd0);
    next();
    sample();
    check("run2_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    next();

    // Re-entry waits a full period
    p0 = cyc;
    bus.run_req = 1'b1;
    exp_tick.push_back(p0 + 16);
    repeat (20) next();
    bus.run_req = 1'b0;
    sample();
    next();
    sample();
    check("run3_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    next();

    // Three single steps from HALT
    for (int k = 0; k < 3; k++) begin
      s = cyc;
      bus.step_req = 1'b1;
      exp_tick.push_back(s + 1);
      next();
      bus.step_req = 1'b0;
      sample();
      check("step_state", {30'd0, bus.state}, {30'd0, S_STEP});
      next();
      sample();
      check("step_back_halt", {30'd0, bus.state}, {30'd0, S_HALT});
      repeat (3) next();
    end

    // Reset in the middle of a load
    bus.load_start = 1'b1;
    sample();
    next();
    bus.load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hC0 + 8'(k);
      exp_wr.push_back('{a: 8'(k), d: 8'hC0 + 8'(k)});
      sample();
      next();
    end
    bus.load_valid = 1'b0;
    sample();
    check("midrst_in_load", {30'd0, bus.state}, {30'd0, S_LOAD});
    next();
    rst = 1'b0;
    #1;
    check("midrst_state", {30'd0, bus.state}, {30'd0, S_HALT});
    check("midrst_count", {23'd0, bus.load_count}, 32'd0);
    check("midrst_ready", {31'd0, bus.load_ready}, 32'd0);
    next();
    rst = 1'b1;
    next();

    // load_start and step_req together in HALT: load wins
    bus.load_start = 1'b1;
    bus.step_req   = 1'b1;
    sample();
    next();
    bus.load_start = 1'b0;
    bus.step_req   = 1'b0;
    sample();
    check("simul_state", {30'd0, bus.state}, {30'd0, S_LOAD});
    next();
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    bus.load_data  = 8'h77;
    exp_wr.push_back('{a: 8'h00, d: 8'h77});
    sample();
    next();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    sample();
    check("simul_exit_state", {30'd0, bus.state}, {30'd0, S_HALT});
    check("simul_count", {23'd0, bus.load_count}, 32'd1);
    next();

    repeat (5) next();
    check("writes_left", exp_wr.size(), 32'd0);
    check("ticks_left", exp_tick.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
